sevenseg_scan_decoder: RTL and testbench

Receive-side counterpart of the team's hex-to-seven-segment encoder. The block samples a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode strobes) and reconstructs the 4-bit hex value shown on each digit. It sits between external display pins, or a display driver under test, and on-chip logic or scoreboards that need the displayed values.

---
 rtl/sevenseg_scan_decoder.sv | 152 +++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - samples a multiplexed active-low 7-seg bus and recovers per-digit hex values
module sevenseg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segment,
  input  logic [NUM_DIGITS-1:0]   anode_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    pattern_err,
  output logic                    anode_err,
  output logic                    frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 7;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  logic [6:0]            segment_s1, segment_s2;
  logic [NUM_DIGITS-1:0] anode_s1, anode_s2;
  logic [SW-1:0]         sample, prev_sample;
  logic [CW-1:0]         cnt;
  state_t                state, state_next;
  logic                  changed, no_anode, capture;
  logic [3:0]            zero_cnt;
  logic [IW-1:0]         zero_idx;
  logic [4:0]            decoded;
  logic                  is_blank;
  logic [NUM_DIGITS-1:0] seen, seen_base, seen_set;
  logic                  seen_full;

  // Returns {legal, nibble}; anything outside the sixteen hex glyphs is illegal.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'b1000000: decode_glyph = {1'b1, 4'h0};
      7'b1111001: decode_glyph = {1'b1, 4'h1};
      7'b0100100: decode_glyph = {1'b1, 4'h2};
      7'b0110000: decode_glyph = {1'b1, 4'h3};
      7'b0011001: decode_glyph = {1'b1, 4'h4};
      7'b0010010: decode_glyph = {1'b1, 4'h5};
      7'b0000010: decode_glyph = {1'b1, 4'h6};
      7'b1111000: decode_glyph = {1'b1, 4'h7};
      7'b0000000: decode_glyph = {1'b1, 4'h8};
      7'b0010000: decode_glyph = {1'b1, 4'h9};
      7'b0100000: decode_glyph = {1'b1, 4'hA};
      7'b0000011: decode_glyph = {1'b1, 4'hB};
      7'b1000110: decode_glyph = {1'b1, 4'hC};
      7'b0100001: decode_glyph = {1'b1, 4'hD};
      7'b0000110: decode_glyph = {1'b1, 4'hE};
      7'b0001110: decode_glyph = {1'b1, 4'hF};
      default:    decode_glyph = 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segment_s1  <= '1;
      segment_s2  <= '1;
      anode_s1    <= '1;
      anode_s2    <= '1;
      prev_sample <= '1;
      cnt         <= '0;
      state       <= IDLE;
    end else begin
      segment_s1  <= segment;
      segment_s2  <= segment_s1;
      anode_s1    <= anode_n;
      anode_s2    <= anode_s1;
      prev_sample <= sample;
      state       <= state_next;
      if (changed)
        cnt <= CW'(1);
      else if (cnt != STABLE_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  assign sample   = {anode_s2, segment_s2};
  assign changed  = (sample != prev_sample);
  assign no_anode = &sample[SW-1:7];
  assign decoded  = decode_glyph(sample[6:0]);
  assign is_blank = &sample[6:0];

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    if (changed) begin
      state_next = no_anode ? IDLE : SETTLE;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == STABLE_MAX) begin
            capture    = 1'b1;
            state_next = HELD;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    zero_cnt = 4'd0;
    zero_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sample[7+i]) begin
        zero_cnt = zero_cnt + 4'd1;
        zero_idx = IW'(i);
      end
    end
  end

  // A capture on the clearing edge lands in the fresh mask.
  assign seen_full = &seen;
  assign seen_base = seen_full ? '0 : seen;
  assign seen_set  = (capture && zero_cnt == 4'd1) ? (NUM_DIGITS'(1) << zero_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value       <= '0;
      digit_valid <= '0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
      frame_done  <= seen_full;
      seen        <= seen_base | seen_set;
      if (capture) begin
        if (zero_cnt == 4'd1) begin
          if (decoded[4]) begin
            value[4*zero_idx +: 4] <= decoded[3:0];
            digit_valid[zero_idx]  <= 1'b1;
          end else begin
            digit_valid[zero_idx] <= 1'b0;
            pattern_err           <= !is_blank;
          end
        end else if (zero_cnt > 4'd1) begin
          anode_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb/tb_sevenseg_scan_decoder.sv - directed bench with a run-length reference model for sevenseg_scan_decoder
module tb_sevenseg_scan_decoder;

  localparam int N = 4;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic [4*N-1:0] value;
  logic [N-1:0]  digit_valid;
  logic          pattern_err, anode_err, frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0, pe_cnt = 0, ae_cnt = 0;
  int base;
  bit chk_en = 1'b0;

  // Reference model state: two-cycle input delay, run length of the delayed input.
  logic [N+6:0]   p0, p1, last_s;
  int             run;
  logic [4*N-1:0] m_value;
  logic [N-1:0]   m_dv, m_seen;
  logic           m_pe, m_ae, m_fd;
  logic [6:0]     glyph [16];

  sevenseg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(rst), .segment(seg), .anode_n(an),
    .value(value), .digit_valid(digit_valid), .pattern_err(pattern_err),
    .anode_err(anode_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    p0 = '1; p1 = '1; last_s = '1; run = 1000;
    m_value = '0; m_dv = '0; m_seen = '0;
    m_pe = 1'b0; m_ae = 1'b0; m_fd = 1'b0;
  endtask

  task automatic model_edge();
    logic [N+6:0] d;
    int zeros, idx, k;
    bit found;
    if (rst) begin
      model_reset();
      return;
    end
    d = p1; p1 = p0; p0 = {an, seg};
    m_pe = 1'b0; m_ae = 1'b0;
    m_fd = (m_seen == '1);
    if (m_fd) m_seen = '0;
    if (d == last_s) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    last_s = d;
    if (run == S + 1) begin
      zeros = 0; idx = 0;
      for (int i = 0; i < N; i++)
        if (!d[7+i]) begin zeros++; idx = i; end
      if (zeros > 1) begin
        m_ae = 1'b1;
      end else if (zeros == 1) begin
        m_seen[idx] = 1'b1;
        found = 1'b0; k = 0;
        for (int g = 0; g < 16; g++)
          if (glyph[g] == d[6:0]) begin found = 1'b1; k = g; end
        if (found) begin
          m_value[4*idx +: 4] = 4'(k);
          m_dv[idx] = 1'b1;
        end else begin
          m_dv[idx] = 1'b0;
          m_pe = (d[6:0] != 7'h7F);
        end
      end
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [N-1:0] a);
    seg = s; an = a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("value", 32'(value), 32'(m_value));
      check("digit_valid", 32'(digit_valid), 32'(m_dv));
      check("pattern_err", 32'(pattern_err), 32'(m_pe));
      check("anode_err", 32'(anode_err), 32'(m_ae));
      check("frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      fd_cnt += int'(frame_done);
      pe_cnt += int'(pattern_err);
      ae_cnt += int'(anode_err);
    end
  end

  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0100000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

    rst = 1'b1; seg = '1; an = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_pulses", {29'd0, pattern_err, anode_err, frame_done}, 32'h0);
    rst = 1'b0;

    // Single digit, latency boundary at edge S+2.
    base = pe_cnt + ae_cnt;
    for (int i = 0; i < 10; i++) begin
      step(7'b0110000, 4'b1110);
      if (i == 5) check("latency_early_valid", 32'(digit_valid), 32'h0);
      if (i == 6) begin
        check("latency_value", 32'(value[3:0]), 32'h3);
        check("latency_valid", 32'(digit_valid), 32'h1);
      end
    end
    check("single_no_err", 32'(pe_cnt + ae_cnt - base), 32'h0);

    // Full scan F, A, 0, 7.
    base = fd_cnt;
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 8; i++)
        case (d)
          0: step(7'b0001110, 4'b1110);
          1: step(7'b0100000, 4'b1101);
          2: step(7'b1000000, 4'b1011);
          default: step(7'b1111000, 4'b0111);
        endcase
    step(7'b1111000, 4'b0111);
    step(7'b1111000, 4'b0111);
    check("scan_value", 32'(value), 32'h70AF);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_frame_done", 32'(fd_cnt - base), 32'h1);

    // Digit 1 toggling faster than the dwell.
    for (int i = 0; i < 12; i++)
      step(((i / 2) % 2 == 0) ? 7'b0100100 : 7'b0000000, 4'b1101);
    check("toggle_no_capture", 32'(value[7:4]), 32'hA);
    for (int i = 0; i < 8; i++) step(7'b0000000, 4'b1101);
    check("toggle_final", 32'(value[7:4]), 32'h8);

    // Two anodes at once.
    base = ae_cnt;
    for (int i = 0; i < 8; i++) step(7'b0110000, 4'b1001);
    check("multi_anode_err", 32'(ae_cnt - base), 32'h1);
    check("multi_anode_value", 32'(value), 32'h708F);
    check("multi_anode_valid", 32'(digit_valid), 32'hF);

    // Digit 2: legal, dash, legal, blank.
    for (int i = 0; i < 8; i++) step(7'b0010010, 4'b1011);
    check("d2_value", 32'(value[11:8]), 32'h5);
    base = pe_cnt;
    for (int i = 0; i < 8; i++) step(7'b0111111, 4'b1011);
    check("dash_err", 32'(pe_cnt - base), 32'h1);
    check("dash_valid", 32'(digit_valid[2]), 32'h0);
    check("dash_value_kept", 32'(value[11:8]), 32'h5);
    for (int i = 0; i < 8; i++) step(7'b0010010, 4'b1011);
    check("d2_revalid", 32'(digit_valid[2]), 32'h1);
    base = pe_cnt;
    for (int i = 0; i < 8; i++) step(7'b1111111, 4'b1011);
    check("blank_valid", 32'(digit_valid[2]), 32'h0);
    check("blank_no_err", 32'(pe_cnt - base), 32'h0);

    // Reset in the middle of a dwell.
    for (int i = 0; i < 5; i++) step(7'b1111001, 4'b1110);
    rst = 1'b1;
    model_reset();
    #1;
    check("midreset_value", 32'(value), 32'h0);
    check("midreset_valid", 32'(digit_valid), 32'h0);
    step(7'b1111001, 4'b1110);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(7'b1111001, 4'b1110);
      if (i == 5) check("post_reset_early", 32'(digit_valid), 32'h0);
      if (i == 6) begin
        check("post_reset_value", 32'(value[3:0]), 32'h1);
        check("post_reset_valid", 32'(digit_valid), 32'h1);
      end
    end

    for (int i = 0; i < 4; i++) step(7'b1111111, 4'b1111);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
